uart_tx_param: RTL and testbench

UART_TX_PARAM -- requirements
Module: uart_tx_param

---
 rtl/uart_tx_param.sv | 185 ++++++++++++++++++
 tb/tb_uart_tx_param.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_param.sv
// UART transmitter with a TX FIFO, runtime parity/stop/baud selection latched per frame.
// Serial output, busy and s_ready are registered; fifo_count excludes the word on the wire.
module uart_tx_param #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          s_valid,
    input  logic [DATA_BITS-1:0]          s_data,
    output logic                          s_ready,
    input  logic [1:0]                    parity_mode,
    input  logic                          two_stop,
    input  logic [DIV_W-1:0]              div_override,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int CW      = AW + 1;
    localparam int DIV_DEF = CLK_FREQ / BAUD;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]        wptr_q, rptr_q;
    logic [CW-1:0]        count_q, count_d;
    logic                 ready_q;
    logic                 push, pop;

    state_t               state_q;
    logic [DIV_W-1:0]     cnt_q, div_q, div_d;
    logic [DATA_BITS-1:0] shreg_q;
    logic [3:0]           bit_idx_q;
    logic                 par_en_q, par_bit_q, stop2_q;
    logic                 tx_q, busy_q;
    logic                 bit_end, frame_done;
    logic [DATA_BITS-1:0] rd_data;

    assign push       = s_valid & ready_q;
    assign rd_data    = mem_q[rptr_q];
    assign bit_end    = (cnt_q == div_q - DIV_W'(1));
    assign frame_done = (state_q == STOP) && bit_end && !stop2_q;
    // A word leaves the FIFO either from IDLE or on the last stop cycle, giving back-to-back frames.
    assign pop        = (count_q != '0) && ((state_q == IDLE) || frame_done);

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        div_d = div_override;
        if (div_override == '0)
            div_d = DIV_W'(DIV_DEF);
        else if (div_override == DIV_W'(1))
            div_d = DIV_W'(2);
    end

    always_ff @(posedge clk) begin
        if (push)
            mem_q[wptr_q] <= s_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ready_q <= 1'b0;
        end else begin
            if (push)
                wptr_q <= wptr_q + AW'(1);
            if (pop)
                rptr_q <= rptr_q + AW'(1);
            count_q <= count_d;
            ready_q <= (count_d < CW'(FIFO_DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            div_q     <= '0;
            shreg_q   <= '0;
            bit_idx_q <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            stop2_q   <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            busy_q <= (count_d != '0) || pop || ((state_q != IDLE) && !frame_done);
            if (pop) begin
                // Frame settings are captured here so mid-frame input changes are ignored.
                state_q   <= START;
                tx_q      <= 1'b0;
                cnt_q     <= '0;
                div_q     <= div_d;
                shreg_q   <= rd_data;
                bit_idx_q <= '0;
                par_en_q  <= (parity_mode == 2'b01) || (parity_mode == 2'b10);
                par_bit_q <= (^rd_data) ^ (parity_mode == 2'b10);
                stop2_q   <= two_stop;
            end else begin
                case (state_q)
                    IDLE: begin
                        tx_q  <= 1'b1;
                        cnt_q <= '0;
                    end
                    START: begin
                        if (bit_end) begin
                            state_q   <= DATA;
                            tx_q      <= shreg_q[0];
                            cnt_q     <= '0;
                            bit_idx_q <= '0;
                        end else begin
                            cnt_q <= cnt_q + DIV_W'(1);
                        end
                    end
                    DATA: begin
                        if (bit_end) begin
                            cnt_q <= '0;
                            if (bit_idx_q == 4'(DATA_BITS - 1)) begin
                                if (par_en_q) begin
                                    state_q <= PARITY;
                                    tx_q    <= par_bit_q;
                                end else begin
                                    state_q <= STOP;
                                    tx_q    <= 1'b1;
                                end
                            end else begin
                                bit_idx_q <= bit_idx_q + 4'd1;
                                shreg_q   <= shreg_q >> 1;
                                tx_q      <= shreg_q[1];
                            end
                        end else begin
                            cnt_q <= cnt_q + DIV_W'(1);
                        end
                    end
                    PARITY: begin
                        if (bit_end) begin
                            state_q <= STOP;
                            tx_q    <= 1'b1;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + DIV_W'(1);
                        end
                    end
                    STOP: begin
                        tx_q <= 1'b1;
                        if (bit_end) begin
                            cnt_q <= '0;
                            if (stop2_q)
                                stop2_q <= 1'b0;
                            else
                                state_q <= IDLE;
                        end else begin
                            cnt_q <= cnt_q + DIV_W'(1);
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        tx_q    <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign s_ready    = ready_q;
    assign tx         = tx_q;
    assign busy       = busy_q;
    assign fifo_count = count_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: queue-based line model checked every cycle, plus literal frame pins.
module tb_uart_tx_param;

    localparam int DW      = 8;
    localparam int DEPTH   = 16;
    localparam int DIV_DEF = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_valid = 1'b0;
    logic [7:0]  s_data = '0;
    logic [1:0]  parity_mode = '0;
    logic        two_stop = 1'b0;
    logic [15:0] div_override = '0;
    logic        s_ready, tx, busy;
    logic [4:0]  fifo_count;

    always #5 clk = ~clk;

    uart_tx_param #(
        .CLK_FREQ  (1_000_000),
        .BAUD      (100_000),
        .DATA_BITS (DW),
        .FIFO_DEPTH(DEPTH),
        .DIV_W     (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .s_valid     (s_valid),
        .s_data      (s_data),
        .s_ready     (s_ready),
        .parity_mode (parity_mode),
        .two_stop    (two_stop),
        .div_override(div_override),
        .tx          (tx),
        .busy        (busy),
        .fifo_count  (fifo_count)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: queued words plus a per-cycle list of line levels for the frame on the wire.
    logic [7:0] mfifo[$];
    bit         mline[$];
    logic       m_tx = 1'b1, m_busy = 1'b0, m_ready = 1'b0;
    int         m_cnt = 0;
    bit         m_valid = 1'b0;

    function automatic void build_frame(input logic [7:0] w);
        int d;
        bit lv[$];
        if (div_override == 0)      d = DIV_DEF;
        else if (div_override == 1) d = 2;
        else                        d = int'(div_override);
        lv.push_back(1'b0);
        for (int i = 0; i < DW; i++) lv.push_back(w[i]);
        if (parity_mode == 2'b01)      lv.push_back(^w);
        else if (parity_mode == 2'b10) lv.push_back(~^w);
        lv.push_back(1'b1);
        if (two_stop) lv.push_back(1'b1);
        foreach (lv[i])
            for (int j = 0; j < d; j++) mline.push_back(lv[i]);
    endfunction

    always @(posedge clk) begin
        bit pushing;
        bit in_frame;
        logic [7:0] w;
        m_valid = 1'b1;
        if (rst) begin
            mfifo.delete();
            mline.delete();
            m_tx = 1'b1; m_busy = 1'b0; m_cnt = 0; m_ready = 1'b0;
        end else begin
            pushing = s_valid && m_ready;
            if (mline.size() == 0 && mfifo.size() != 0) begin
                w = mfifo.pop_front();
                build_frame(w);
            end
            if (mline.size() != 0) begin
                m_tx = mline.pop_front();
                in_frame = 1'b1;
            end else begin
                m_tx = 1'b1;
                in_frame = 1'b0;
            end
            if (pushing) mfifo.push_back(s_data);
            m_busy  = in_frame || (mfifo.size() != 0);
            m_cnt   = mfifo.size();
            m_ready = (mfifo.size() < DEPTH);
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("tx", tx, m_tx);
            chk("busy", busy, m_busy);
            chk("fifo_count", fifo_count, m_cnt);
            chk("s_ready", s_ready, m_ready);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget && busy; i++) tick();
        chk("idle_reached", busy, 1'b0);
    endtask

    task automatic record(input string name, input logic [7:0] w, input int n,
                          input logic [63:0] exp, input int flip_at);
        logic [63:0] rec;
        rec = '0;
        s_data  = w;
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (i == flip_at) two_stop = ~two_stop;
            tick();
            rec[n-1-i] = tx;
        end
        chk(name, rec, exp);
        chk({name, "_busy_last"}, busy, 1'b1);
        tick();
        chk({name, "_busy_fall"}, busy, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("ready_after_rst", s_ready, 1'b1);
        chk("tx_after_rst", tx, 1'b1);
        chk("busy_after_rst", busy, 1'b0);
        chk("count_after_rst", fifo_count, 5'd0);

        div_override = 16'd4;
        parity_mode  = 2'b00;
        two_stop     = 1'b0;
        record("frame_a5", 8'hA5, 40, 64'h0F0F00F0FF, -1);
        parity_mode = 2'b01;
        record("frame_07_even", 8'h07, 44, 64'h0FFF00000FF, -1);
        parity_mode = 2'b10;
        record("frame_07_odd", 8'h07, 44, 64'h0FFF000000F, -1);
        parity_mode = 2'b00;
        two_stop    = 1'b1;
        record("frame_two_stop", 8'h00, 44, 64'h000000000FF, 10);
        two_stop = 1'b0;

        for (int j = 0; j < 17; j++) begin
            s_data  = 8'($urandom);
            s_valid = 1'b1;
            for (int t = 0; t < 200 && !s_ready; t++) tick();
            tick();
        end
        s_valid = 1'b0;
        chk("burst_count_full", fifo_count, 5'd16);
        chk("burst_ready_low", s_ready, 1'b0);
        wait_idle(2000);
        chk("burst_count_drained", fifo_count, 5'd0);

        s_data  = 8'h3C;
        s_valid = 1'b1;
        repeat (4) tick();
        s_valid = 1'b0;
        chk("pre_rst_count", fifo_count, 5'd3);
        repeat (8) tick();
        rst = 1'b1;
        tick();
        chk("midrst_tx", tx, 1'b1);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_count", fifo_count, 5'd0);
        chk("midrst_ready", s_ready, 1'b0);
        rst = 1'b0;
        tick();
        chk("postrst_ready", s_ready, 1'b1);
        record("frame_55_post_rst", 8'h55, 40, 64'h0F0F0F0F0F, -1);

        for (int c = 0; c < 3000; c++) begin
            s_valid = ($urandom_range(0, 3) == 0);
            s_data  = 8'($urandom);
            if ($urandom_range(0, 7) == 0) parity_mode = 2'($urandom);
            if ($urandom_range(0, 7) == 0) two_stop = 1'($urandom);
            div_override = 16'($urandom_range(0, 5));
            rst = ($urandom_range(0, 399) == 0);
            tick();
        end
        rst     = 1'b0;
        s_valid = 1'b0;
        wait_idle(5000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        n_bad++;
        $display("FAIL watchdog: got timeout expected completion at %0t", $time);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog expired");
    end

endmodule
